// File: rtl/mem_arbiter.sv
// Memory arbiter: serialises loader, instruction-fetch and data-port
// accesses onto a single sdram_ctl command port. Loader has fixed top
// priority; fetch and data share the remaining slot round-robin.
// Data accesses above DRAM_LAST are answered locally without touching SDRAM.
module mem_arbiter #(
  parameter int WORD_WIDTH = 16,
  parameter int DRAM_ADDR_WIDTH = 25,
  parameter logic [WORD_WIDTH-1:0] DRAM_LAST = 16'hF7FF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_req,
  input  logic [WORD_WIDTH-1:0]      ld_addr,
  input  logic [WORD_WIDTH-1:0]      ld_wdata,
  output logic                       ld_ack,
  input  logic                       if_req,
  input  logic [WORD_WIDTH-1:0]      if_addr,
  output logic                       if_ack,
  output logic [WORD_WIDTH-1:0]      if_rdata,
  input  logic                       dm_req,
  input  logic                       dm_we,
  input  logic [WORD_WIDTH-1:0]      dm_addr,
  input  logic [WORD_WIDTH-1:0]      dm_wdata,
  output logic                       dm_ack,
  output logic [WORD_WIDTH-1:0]      dm_rdata,
  output logic                       ctl_req,
  output logic                       ctl_we,
  output logic [DRAM_ADDR_WIDTH-1:0] ctl_addr,
  output logic [WORD_WIDTH-1:0]      ctl_wdata,
  input  logic [WORD_WIDTH-1:0]      ctl_rdata,
  input  logic                       ctl_done,
  output logic                       busy,
  output logic                       err
);

  // Counter is at least 8 bits and grows if a longer timeout is configured.
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {G_LD, G_IF, G_DM} gnt_t;

  state_t           state;
  gnt_t             gnt;
  logic             last_dm;   // 1: data port was served most recently
  logic [CNT_W-1:0] wait_cnt;

  logic                  pick_if, pick_dm, tmo;
  logic [WORD_WIDTH-1:0] fin_data;

  // Arbitration and completion selection for the current cycle.
  always_comb begin
    pick_if  = !ld_req && if_req && (!dm_req || last_dm);
    pick_dm  = !ld_req && dm_req && (!if_req || !last_dm);
    tmo      = (wait_cnt >= CNT_LAST);
    fin_data = ctl_done ? ctl_rdata : '1;
  end

  // Main FSM; every output is registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt       <= G_LD;
      last_dm   <= 1'b1;
      wait_cnt  <= '0;
      ld_ack    <= 1'b0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      ctl_req   <= 1'b0;
      ctl_we    <= 1'b0;
      ctl_addr  <= '0;
      ctl_wdata <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_req) begin
            gnt       <= G_LD;
            ctl_we    <= 1'b1;
            ctl_addr  <= DRAM_ADDR_WIDTH'(ld_addr);
            ctl_wdata <= ld_wdata;
            ctl_req   <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end else if (pick_if) begin
            gnt       <= G_IF;
            ctl_we    <= 1'b0;
            ctl_addr  <= DRAM_ADDR_WIDTH'(if_addr);
            ctl_wdata <= '0;
            ctl_req   <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end else if (pick_dm) begin
            gnt  <= G_DM;
            busy <= 1'b1;
            if (dm_addr <= DRAM_LAST) begin
              ctl_we    <= dm_we;
              ctl_addr  <= DRAM_ADDR_WIDTH'(dm_addr);
              ctl_wdata <= dm_wdata;
              ctl_req   <= 1'b1;
              state     <= ISSUE;
            end else begin
              // Unmapped: writes vanish, reads return zero, no SDRAM traffic.
              dm_ack   <= 1'b1;
              dm_rdata <= '0;
              state    <= RESP;
            end
          end
        end
        ISSUE: begin
          ctl_req  <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (ctl_done || tmo) begin
            case (gnt)
              G_IF: begin
                if_rdata <= fin_data;
                if_ack   <= 1'b1;
              end
              G_DM: begin
                dm_rdata <= fin_data;
                dm_ack   <= 1'b1;
              end
              default: ld_ack <= 1'b1;
            endcase
            err   <= !ctl_done;
            state <= RESP;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          ld_ack   <= 1'b0;
          if_ack   <= 1'b0;
          dm_ack   <= 1'b0;
          err      <= 1'b0;
          busy     <= 1'b0;
          wait_cnt <= '0;
          if (gnt == G_IF) last_dm <= 1'b0;
          if (gnt == G_DM) last_dm <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small SDRAM responder answers each
// command with addr ^ 16'h5A5A after a programmable delay, and a scoreboard
// of expected acknowledgements is drained as the arbiter answers.
module tb_mem_arbiter;

  localparam int TMO = 255;

  logic        clk, rst;
  logic        ld_req, ld_ack, if_req, if_ack, dm_req, dm_we, dm_ack;
  logic [15:0] ld_addr, ld_wdata, if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic        ctl_req, ctl_we, ctl_done, busy, err;
  logic [24:0] ctl_addr;
  logic [15:0] ctl_wdata, ctl_rdata;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .ctl_req(ctl_req), .ctl_we(ctl_we), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
    .ctl_rdata(ctl_rdata), .ctl_done(ctl_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // kind: 0 = SDRAM completion, 1 = unmapped local answer, 2 = timeout
  typedef struct {int port; logic [15:0] rdata; int kind; int set_cyc;} exp_t;
  typedef struct {logic we; logic [24:0] addr; logic [15:0] wdata;} cmd_t;

  exp_t exp_q[$];
  cmd_t cmd_q[$];
  cmd_t cur_cmd;

  int n_assert = 0, n_fail = 0;
  int cyc = 0, done_cyc = -1, ctlreq_cyc = -1, done_cnt = 0, resp_delay = 4;
  bit resp_en = 1, hold_chk = 0, prev_ctl_req = 0;
  logic [15:0] pend_rdata = '0;
  int t0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int port, input logic [15:0] rd, input int kind);
    exp_q.push_back('{port, rd, kind, cyc});
  endtask

  task automatic push_cmd(input logic we, input logic [15:0] addr, input logic [15:0] wd);
    cmd_q.push_back('{we, 25'(addr), wd});
  endtask

  // One cycle: observe outputs at the falling edge, play the SDRAM side,
  // retire acknowledgements against the scoreboard, drop served requests.
  task automatic tick();
    int   nack, port, exp_cyc;
    exp_t e;
    cmd_t c;
    @(negedge clk);
    cyc++;
    ctl_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        ctl_done  = 1'b1;
        ctl_rdata = pend_rdata;
        done_cyc  = cyc;
        if (hold_chk) begin
          check("hold_addr", ctl_addr, cur_cmd.addr);
          check("hold_we", ctl_we, cur_cmd.we);
          if (cur_cmd.we) check("hold_wdata", ctl_wdata, cur_cmd.wdata);
        end
      end
    end
    if (ctl_req) begin
      check("ctl_req_one_cycle", prev_ctl_req, 0);
      check("busy_issue", busy, 1);
      check("cmd_expected", cmd_q.size() > 0, 1);
      if (cmd_q.size() > 0) begin
        c = cmd_q.pop_front();
        check("ctl_we", ctl_we, c.we);
        check("ctl_addr", ctl_addr, c.addr);
        if (c.we) check("ctl_wdata", ctl_wdata, c.wdata);
        cur_cmd    = c;
        hold_chk   = 1;
        ctlreq_cyc = cyc;
        if (resp_en) begin
          done_cnt   = resp_delay;
          pend_rdata = c.addr[15:0] ^ 16'h5A5A;
        end
      end
    end
    prev_ctl_req = ctl_req;
    nack = int'(ld_ack) + int'(if_ack) + int'(dm_ack);
    check("err_only_with_ack", err & (nack == 0), 0);
    if (nack > 0) begin
      check("ack_onehot", nack, 1);
      check("ack_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        port = ld_ack ? 0 : (if_ack ? 1 : 2);
        check("ack_port", port, e.port);
        if (e.port == 1) check("if_rdata", if_rdata, e.rdata);
        if (e.port == 2) check("dm_rdata", dm_rdata, e.rdata);
        check("err_with_ack", err, e.kind == 2);
        check("busy_resp", busy, 1);
        case (e.kind)
          0:       exp_cyc = done_cyc + 1;
          1:       exp_cyc = e.set_cyc + 1;
          default: exp_cyc = ctlreq_cyc + TMO + 1;
        endcase
        check("ack_latency", cyc, exp_cyc);
      end
      if (ld_ack) ld_req = 1'b0;
      if (if_ack) if_req = 1'b0;
      if (dm_ack) dm_req = 1'b0;
    end
  endtask

  task automatic run(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (exp_q.size() == 0 && cmd_q.size() == 0 && !busy && !ld_req && !if_req && !dm_req)
        ok = 1;
    end
    check("run_complete", ok, 1);
  endtask

  initial begin
    clk = 0; rst = 0;
    ld_req = 0; ld_addr = 0; ld_wdata = 0;
    if_req = 0; if_addr = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    ctl_done = 0; ctl_rdata = 0;
    repeat (3) tick();

    // Reset state
    check("rst_ld_ack", ld_ack, 0);
    check("rst_if_ack", if_ack, 0);
    check("rst_dm_ack", dm_ack, 0);
    check("rst_ctl_req", ctl_req, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_ctl_addr", ctl_addr, 0);
    check("rst_ctl_we", ctl_we, 0);
    check("rst_ctl_wdata", ctl_wdata, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    rst = 1;
    tick();

    // Loader write, done 4 cycles after the command
    resp_delay = 4;
    push_cmd(1, 16'h0003, 16'hBEEF);
    push_exp(0, 16'h0, 0);
    t0 = cyc;
    ld_req = 1; ld_addr = 16'h0003; ld_wdata = 16'hBEEF;
    run(40);
    check("ld_issue_latency", ctlreq_cyc, t0 + 1);
    check("ld_done_delay", done_cyc, ctlreq_cyc + 4);

    // Fetch/data tie after reset: fetch first
    resp_delay = 2;
    push_cmd(0, 16'h0020, 16'h0); push_exp(1, 16'h0020 ^ 16'h5A5A, 0);
    push_cmd(0, 16'h0010, 16'h0); push_exp(2, 16'h0010 ^ 16'h5A5A, 0);
    if_req = 1; if_addr = 16'h0020;
    dm_req = 1; dm_we = 0; dm_addr = 16'h0010;
    run(60);

    // All three: loader, then fetch (data last served), then data write
    resp_delay = 3;
    push_cmd(1, 16'h0100, 16'h1234); push_exp(0, 16'h0, 0);
    push_cmd(0, 16'h0200, 16'h0);    push_exp(1, 16'h0200 ^ 16'h5A5A, 0);
    push_cmd(1, 16'h0300, 16'hCAFE); push_exp(2, 16'h0300 ^ 16'h5A5A, 0);
    ld_req = 1; ld_addr = 16'h0100; ld_wdata = 16'h1234;
    if_req = 1; if_addr = 16'h0200;
    dm_req = 1; dm_we = 1; dm_addr = 16'h0300; dm_wdata = 16'hCAFE;
    run(80);

    // Fetch alone, data read value must be retained
    resp_delay = 1;
    push_cmd(0, 16'h0400, 16'h0); push_exp(1, 16'h0400 ^ 16'h5A5A, 0);
    if_req = 1; if_addr = 16'h0400;
    run(30);
    check("dm_rdata_hold", dm_rdata, 16'h0300 ^ 16'h5A5A);

    // Tie with fetch last served: data wins
    resp_delay = 5;
    push_cmd(0, 16'h0420, 16'h0); push_exp(2, 16'h0420 ^ 16'h5A5A, 0);
    push_cmd(0, 16'h0410, 16'h0); push_exp(1, 16'h0410 ^ 16'h5A5A, 0);
    if_req = 1; if_addr = 16'h0410;
    dm_req = 1; dm_we = 0; dm_addr = 16'h0420;
    run(60);

    // Unmapped data write, then the highest mapped address
    push_exp(2, 16'h0000, 1);
    dm_req = 1; dm_we = 1; dm_addr = 16'hF800; dm_wdata = 16'h7777;
    run(20);
    resp_delay = 2;
    push_cmd(0, 16'hF7FF, 16'h0); push_exp(2, 16'hF7FF ^ 16'h5A5A, 0);
    dm_req = 1; dm_we = 0; dm_addr = 16'hF7FF;
    run(30);

    // Timeout on fetch
    resp_en = 0;
    push_cmd(0, 16'h0040, 16'h0); push_exp(1, 16'hFFFF, 2);
    if_req = 1; if_addr = 16'h0040;
    run(TMO + 40);
    check("tmo_if_rdata_hold", if_rdata, 16'hFFFF);
    resp_en = 1;

    // Reset during WAIT; the late done must be ignored
    resp_delay = 8;
    push_cmd(0, 16'h0050, 16'h0);
    t0 = ctlreq_cyc;
    if_req = 1; if_addr = 16'h0050;
    for (int i = 0; i < 20 && ctlreq_cyc == t0; i++) tick();
    check("abort_cmd_issued", ctlreq_cyc != t0, 1);
    repeat (3) tick();
    rst = 0; if_req = 0; hold_chk = 0;
    repeat (2) tick();
    check("abort_busy", busy, 0);
    check("abort_ctl_req", ctl_req, 0);
    check("abort_if_ack", if_ack, 0);
    check("abort_ctl_addr", ctl_addr, 0);
    rst = 1;
    repeat (8) tick();
    check("late_done_seen", done_cyc > ctlreq_cyc, 1);
    check("late_done_busy", busy, 0);
    check("late_done_if_rdata", if_rdata, 0);
    resp_delay = 3;
    push_cmd(0, 16'h0060, 16'h0); push_exp(1, 16'h0060 ^ 16'h5A5A, 0);
    if_req = 1; if_addr = 16'h0060;
    run(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
